// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch
// and the load/store stage, one transaction at a time.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_D = 2'd1;
  localparam logic [1:0] BUSY_I = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]    state;
  logic          resp_d;
  logic          resp_err;
  logic [SW-1:0] starve;
  logic [TW-1:0] tcnt;
  logic          pick_d;
  logic          pick_i;
  logic          starved;
  logic          expired;

  assign starved = (starve == SW'(STARVE_MAX));
  assign expired = (tcnt == TW'(TIMEOUT - 1));

  // Grants are gated by reset so every output is quiet while held.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (state == IDLE && reset) begin
      if (d_req && (!i_req || !starved))
        pick_d = 1'b1;
      else if (i_req)
        pick_i = 1'b1;
    end
  end

  assign d_gnt  = pick_d;
  assign i_gnt  = pick_i;
  assign d_done = (state == RESP) && resp_d;
  assign i_done = (state == RESP) && !resp_d;
  assign err    = (state == RESP) && resp_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      resp_d   <= 1'b0;
      resp_err <= 1'b0;
      starve   <= '0;
      tcnt     <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            tcnt    <= '0;
            if (!i_req)
              starve <= '0;
            else if (!starved)
              starve <= starve + 1'b1;
          end else if (pick_i) begin
            state   <= BUSY_I;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            tcnt    <= '0;
            starve  <= '0;
          end
        end
        BUSY_D, BUSY_I: begin
          if (m_ack) begin
            state    <= RESP;
            m_req    <= 1'b0;
            resp_d   <= (state == BUSY_D);
            resp_err <= 1'b0;
            if (state == BUSY_D)
              d_rdata <= m_we ? '0 : m_rdata;
            else
              i_rdata <= m_rdata;
          end else if (expired) begin
            state    <= RESP;
            m_req    <= 1'b0;
            resp_d   <= (state == BUSY_D);
            resp_err <= 1'b1;
            if (state == BUSY_D)
              d_rdata <= '0;
            else
              i_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          resp_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small ack-delay memory
// responder and immediate-assertion checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [8:0]  i_addr;
  logic        i_gnt;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;

  int   ack_dly   = 0;
  logic ack_en    = 1'b0;
  logic force_ack = 1'b0;
  int   cyc       = 0;

  mem_port_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_done  (i_done),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .err     (err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ack_dly cycles of m_req.
  always @(negedge clk) begin
    if (m_req) begin
      m_ack <= force_ack || (ack_en && cyc == ack_dly);
      cyc   <= cyc + 1;
    end else begin
      m_ack <= force_ack;
      cyc   <= 0;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int         ng;
  int         last;
  int         both;
  int         n;
  logic [7:0] seq;

  initial begin
    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    tick;
    d_req = 1'b1;
    #1;
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_i_rdata", i_rdata, 0);
    d_req = 1'b0;
    tick;
    reset = 1'b1;
    tick;

    // Load with one cycle of ack delay
    ack_en  = 1'b1;
    ack_dly = 1;
    m_rdata = 32'hDEADBEEF;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 9'h010;
    #1;
    chk("ld_gnt", 32'(d_gnt), 1);
    chk("ld_i_gnt", 32'(i_gnt), 0);
    tick;
    d_req = 1'b0;
    #1;
    chk("ld_m_req", 32'(m_req), 1);
    chk("ld_m_addr", 32'(m_addr), 32'h10);
    chk("ld_m_we", 32'(m_we), 0);
    chk("ld_gnt_pulse", 32'(d_gnt), 0);
    tick;
    chk("ld_done_early", 32'(d_done), 0);
    tick;
    chk("ld_done", 32'(d_done), 1);
    chk("ld_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_err", 32'(err), 0);
    chk("ld_m_req_off", 32'(m_req), 0);
    tick;
    chk("ld_done_pulse", 32'(d_done), 0);

    // Spurious ack while idle
    force_ack = 1'b1;
    m_rdata   = 32'h55555555;
    tick;
    tick;
    chk("sp_d_done", 32'(d_done), 0);
    chk("sp_i_done", 32'(i_done), 0);
    chk("sp_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("sp_m_req", 32'(m_req), 0);
    force_ack = 1'b0;
    tick;

    // Store with immediate ack
    ack_dly = 0;
    m_rdata = 32'hCAFEF00D;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 9'h020;
    d_wdata = 32'h12345678;
    #1;
    chk("st_gnt", 32'(d_gnt), 1);
    tick;
    d_req = 1'b0;
    d_we  = 1'b0;
    #1;
    chk("st_m_we", 32'(m_we), 1);
    chk("st_m_wdata", m_wdata, 32'h12345678);
    chk("st_m_addr", 32'(m_addr), 32'h20);
    tick;
    chk("st_done", 32'(d_done), 1);
    chk("st_rdata", d_rdata, 0);
    chk("st_i_done", 32'(i_done), 0);
    chk("st_i_rdata", i_rdata, 0);
    tick;

    // Fetch that times out
    ack_en = 1'b0;
    i_req  = 1'b1;
    i_addr = 9'h044;
    #1;
    chk("to_gnt", 32'(i_gnt), 1);
    chk("to_d_gnt", 32'(d_gnt), 0);
    tick;
    i_req = 1'b0;
    #1;
    chk("to_m_we", 32'(m_we), 0);
    chk("to_m_wdata", m_wdata, 0);
    chk("to_m_addr", 32'(m_addr), 32'h44);
    n = 0;
    while (m_req && n < 30) begin
      n++;
      tick;
    end
    chk("to_req_cycles", 32'(n), 15);
    chk("to_i_done", 32'(i_done), 1);
    chk("to_err", 32'(err), 1);
    chk("to_i_rdata", i_rdata, 0);
    chk("to_d_done", 32'(d_done), 0);
    tick;
    chk("to_err_pulse", 32'(err), 0);

    // Next fetch completes normally
    ack_en  = 1'b1;
    ack_dly = 0;
    m_rdata = 32'h0BADF00D;
    i_req   = 1'b1;
    i_addr  = 9'h048;
    #1;
    chk("f2_gnt", 32'(i_gnt), 1);
    tick;
    i_req = 1'b0;
    tick;
    chk("f2_done", 32'(i_done), 1);
    chk("f2_err", 32'(err), 0);
    chk("f2_rdata", i_rdata, 32'h0BADF00D);
    tick;

    // Both requesters held: data-first with bounded fetch starvation
    d_req = 1'b1;
    i_req = 1'b1;
    #1;
    ng   = 0;
    last = 0;
    both = 0;
    seq  = '0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      if (d_gnt && i_gnt)
        both++;
      if (d_gnt || i_gnt) begin
        seq  = {seq[6:0], d_gnt};
        ng++;
        last = c;
      end
      tick;
    end
    d_req = 1'b0;
    i_req = 1'b0;
    chk("arb_count", 32'(ng), 8);
    chk("arb_order", 32'(seq), 32'hEE);
    chk("arb_last_cycle", 32'(last), 21);
    chk("arb_both", 32'(both), 0);
    tick;
    tick;
    tick;

    // Reset in the middle of a data transaction
    ack_en = 1'b0;
    d_req  = 1'b1;
    d_addr = 9'h030;
    #1;
    chk("rb_gnt", 32'(d_gnt), 1);
    tick;
    tick;
    chk("rb_m_req", 32'(m_req), 1);
    reset = 1'b0;
    #1;
    chk("rb_m_req_off", 32'(m_req), 0);
    chk("rb_m_addr", 32'(m_addr), 0);
    chk("rb_d_gnt", 32'(d_gnt), 0);
    chk("rb_d_rdata", d_rdata, 0);
    chk("rb_i_rdata", i_rdata, 0);
    tick;
    reset   = 1'b1;
    ack_en  = 1'b1;
    ack_dly = 0;
    #1;
    chk("rb_regnt", 32'(d_gnt), 1);
    chk("rb_no_done", 32'(d_done), 0);
    tick;
    d_req = 1'b0;
    tick;
    chk("rb_done", 32'(d_done), 1);
    chk("rb_rdata", d_rdata, 32'h0BADF00D);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
